// File: rtl/coin_pkg.sv
// Shared coin-bus definitions: coin codes, price, coin value decode and feeder FSM states.
package coin_pkg;

   localparam logic [1:0] COIN_IDLE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;

   localparam int PRICE_U = 4;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_SEND = 2'd1;
   localparam state_t ST_GAP  = 2'd2;

   // Value of a coin code in 5-units; idle and illegal codes are worth nothing.
   function automatic logic [1:0] coin_val(input logic [1:0] code);
      case (code)
         COIN_5:  coin_val = 2'd1;
         COIN_10: coin_val = 2'd2;
         default: coin_val = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_fifo.sv
// Small coin token FIFO with first-word-fall-through head, full/empty flags and
// simultaneous push/pop (a push into a full FIFO is allowed when it pops the same cycle).
module coin_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [1:0]                 push_data,
   input  logic                       pop,
   output logic [1:0]                 head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr_reg];
   assign count   = count_reg;

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/coin_feeder.sv
// Coin bus transmitter: buffers host coins, sends them in gap-free purchase bursts and
// checks the vending controller's dispense/chg5 responses against a shadow credit model.
module coin_feeder
   import coin_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 16,
   parameter int MIN_GAP = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       coin_in,
   input  logic             coin_in_valid,
   output logic             coin_in_ready,
   output logic [1:0]       coin,
   input  logic             dispense,
   input  logic             chg5,
   output logic             busy,
   output logic [CNT_W-1:0] vend_count,
   output logic [CNT_W-1:0] chg_count,
   output logic             proto_err,
   output logic             bad_coin
);

   localparam int BV_W = $clog2(2 * DEPTH + 1);
   localparam int GW   = $clog2(MIN_GAP + 1);

   state_t           state_reg, state_next;
   logic [1:0]       credit_reg, credit_next;
   logic [GW-1:0]    gap_cnt_reg, gap_cnt_next;
   logic [BV_W-1:0]  buf_val_reg, buf_val_next;
   logic [1:0]       coin_reg;
   logic             exp_disp_reg, exp_chg_reg;
   logic [CNT_W-1:0] vend_count_reg, chg_count_reg;
   logic             proto_err_reg, bad_coin_reg;

   logic [1:0]       head;
   logic             fifo_full, fifo_empty;
   logic [$clog2(DEPTH+1)-1:0] fifo_count;
   logic [1:0]       head_val;
   logic [2:0]       credit_sum;
   logic             start, pop, push, tok_ok, store, mismatch;

   coin_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (store),
      .push_data (coin_in),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // The start decision is itself the first pop, so the inter-burst idle run on coin
   // is exactly the GAP length.
   assign start         = (state_reg == ST_IDLE) && (buf_val_reg >= BV_W'(PRICE_U)) && !fifo_empty;
   assign pop           = start || (state_reg == ST_SEND);
   assign coin_in_ready = !fifo_full || pop;
   assign push          = coin_in_valid && coin_in_ready;
   assign tok_ok        = (coin_in == COIN_5) || (coin_in == COIN_10);
   assign store         = push && tok_ok;
   assign head_val      = coin_val(head);
   assign credit_sum    = {1'b0, credit_reg} + {1'b0, head_val};

   always_comb begin
      state_next   = state_reg;
      credit_next  = credit_reg;
      gap_cnt_next = gap_cnt_reg;
      if (pop) begin
         if (credit_sum >= 3'(PRICE_U)) begin
            state_next   = ST_GAP;
            credit_next  = '0;
            gap_cnt_next = '0;
         end else begin
            state_next  = ST_SEND;
            credit_next = credit_sum[1:0];
         end
      end else if (state_reg == ST_GAP) begin
         if (gap_cnt_reg == GW'(MIN_GAP - 1)) state_next = ST_IDLE;
         else                                 gap_cnt_next = gap_cnt_reg + 1'b1;
      end
   end

   assign buf_val_next = buf_val_reg
                       + (store ? BV_W'(coin_val(coin_in)) : '0)
                       - (pop   ? BV_W'(head_val)          : '0);

   // A response is expected only while a coin is on the bus; any pulse on idle is an error.
   assign mismatch = (coin_reg != COIN_IDLE) ? ((dispense != exp_disp_reg) || (chg5 != exp_chg_reg))
                                             : (dispense || chg5);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         credit_reg     <= '0;
         gap_cnt_reg    <= '0;
         buf_val_reg    <= '0;
         coin_reg       <= COIN_IDLE;
         exp_disp_reg   <= 1'b0;
         exp_chg_reg    <= 1'b0;
         vend_count_reg <= '0;
         chg_count_reg  <= '0;
         proto_err_reg  <= 1'b0;
         bad_coin_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         credit_reg   <= credit_next;
         gap_cnt_reg  <= gap_cnt_next;
         buf_val_reg  <= buf_val_next;
         coin_reg     <= pop ? head : COIN_IDLE;
         exp_disp_reg <= pop && (credit_sum >= 3'(PRICE_U));
         exp_chg_reg  <= pop && (credit_sum == 3'(PRICE_U + 1));
         if (dispense && !(&vend_count_reg)) vend_count_reg <= vend_count_reg + 1'b1;
         if (chg5 && !(&chg_count_reg))      chg_count_reg  <= chg_count_reg + 1'b1;
         proto_err_reg <= proto_err_reg | mismatch;
         bad_coin_reg  <= bad_coin_reg | (push && !tok_ok);
      end
   end

   assign coin       = coin_reg;
   assign busy       = (state_reg == ST_SEND);
   assign vend_count = vend_count_reg;
   assign chg_count  = chg_count_reg;
   assign proto_err  = proto_err_reg;
   assign bad_coin   = bad_coin_reg;

endmodule

// File: tb/tb_coin_feeder.sv
// Directed bench for coin_feeder: a behavioural vending controller answers the coin bus
// and every observation is compared against hand-computed values.
module tb_coin_feeder;

   logic        clk;
   logic        rst;
   logic [1:0]  coin_in;
   logic        coin_in_valid;
   logic        coin_in_ready;
   logic [1:0]  coin;
   logic        dispense;
   logic        chg5;
   logic        busy;
   logic [15:0] vend_count;
   logic [15:0] chg_count;
   logic        proto_err;
   logic        bad_coin;

   logic        force_disp;
   logic [2:0]  ctl_credit;
   logic [2:0]  ctl_sum;
   logic [1:0]  log_q[$];
   bit          log_en;
   int          n_checks;
   int          n_pass;

   coin_feeder #(.DEPTH(8), .CNT_W(16), .MIN_GAP(1)) dut (
      .clk           (clk),
      .rst           (rst),
      .coin_in       (coin_in),
      .coin_in_valid (coin_in_valid),
      .coin_in_ready (coin_in_ready),
      .coin          (coin),
      .dispense      (dispense),
      .chg5          (chg5),
      .busy          (busy),
      .vend_count    (vend_count),
      .chg_count     (chg_count),
      .proto_err     (proto_err),
      .bad_coin      (bad_coin)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Vending controller model: Mealy dispense/chg5 in the cycle of the completing coin.
   always_comb begin
      ctl_sum  = ctl_credit + ((coin == 2'b01) ? 3'd1 : (coin == 2'b10) ? 3'd2 : 3'd0);
      dispense = force_disp || ((coin != 2'b00) && (ctl_sum >= 3'd4));
      chg5     = (coin != 2'b00) && (ctl_sum == 3'd5);
   end

   always_ff @(posedge clk) begin
      if (rst)                 ctl_credit <= 3'd0;
      else if (coin != 2'b00)  ctl_credit <= (ctl_sum >= 3'd4) ? 3'd0 : ctl_sum;
   end

   always @(negedge clk) begin
      if (log_en) log_q.push_back(coin);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      else             n_pass++;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      coin_in       = 2'b00;
      coin_in_valid = 1'b0;
      force_disp    = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      log_q.delete();
   endtask

   // Called just after a negedge; returns at a later negedge once the token is taken.
   task automatic push(input logic [1:0] t);
      int waited;
      waited        = 0;
      coin_in       = t;
      coin_in_valid = 1'b1;
      while (!coin_in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) check("push_timeout", 32'(coin_in_ready), 32'd1);
      @(negedge clk);
      coin_in_valid = 1'b0;
   endtask

   // Logged coin stream with leading/trailing idles removed, packed 2 bits per cycle.
   function automatic logic [31:0] trace_pack();
      int first = -1;
      int last  = -1;
      logic [31:0] v = '0;
      foreach (log_q[i]) begin
         if (log_q[i] != 2'b00) begin
            if (first < 0) first = i;
            last = i;
         end
      end
      if (first >= 0) for (int i = first; i <= last; i++) v = {v[29:0], log_q[i]};
      return v;
   endfunction

   initial begin
      int accepted, n_coins, n_fives, waited;
      bit low_seen, rise_seen, rise_pending, found;
      n_checks   = 0;
      n_pass     = 0;
      log_en     = 1'b0;
      force_disp = 1'b0;

      // Reset state
      do_reset();
      check("rst_coin", 32'(coin), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_vend", 32'(vend_count), 32'd0);
      check("rst_chg", 32'(chg_count), 32'd0);
      check("rst_proto", 32'(proto_err), 32'd0);
      check("rst_bad", 32'(bad_coin), 32'd0);
      check("rst_ready", 32'(coin_in_ready), 32'd1);

      // 5+5+10: one gap-free burst, dispense on the third coin
      log_en = 1'b1;
      push(2'b01); push(2'b01); push(2'b10);
      repeat (10) @(negedge clk);
      check("t1_trace", trace_pack(), 32'h16);
      check("t1_vend", 32'(vend_count), 32'd1);
      check("t1_chg", 32'(chg_count), 32'd0);
      check("t1_proto", 32'(proto_err), 32'd0);
      check("t1_busy", 32'(busy), 32'd0);

      // 15 waits below price, then +10 overpays and returns 5
      do_reset();
      push(2'b01); push(2'b01); push(2'b01);
      repeat (20) @(negedge clk);
      check("t2_idle_coin", 32'(coin), 32'd0);
      check("t2_idle_busy", 32'(busy), 32'd0);
      check("t2_bufval", 32'(dut.buf_val_reg), 32'd3);
      push(2'b10);
      repeat (10) @(negedge clk);
      check("t2_trace", trace_pack(), 32'h56);
      check("t2_vend", 32'(vend_count), 32'd1);
      check("t2_chg", 32'(chg_count), 32'd1);
      check("t2_proto", 32'(proto_err), 32'd0);

      // 10,10,10,10: two bursts separated by exactly one idle cycle
      do_reset();
      push(2'b10); push(2'b10); push(2'b10); push(2'b10);
      repeat (15) @(negedge clk);
      check("t3_trace", trace_pack(), 32'h28A);
      check("t3_vend", 32'(vend_count), 32'd2);
      check("t3_chg", 32'(chg_count), 32'd0);
      check("t3_proto", 32'(proto_err), 32'd0);

      // Hold valid with 5s until the FIFO fills; 48 tokens make 12 exact purchases
      do_reset();
      accepted = 0; low_seen = 0; rise_seen = 0; rise_pending = 0;
      coin_in = 2'b01;
      coin_in_valid = 1'b1;
      for (int cyc = 0; cyc < 400 && accepted < 48; cyc++) begin
         if (!coin_in_ready && !low_seen) begin
            low_seen = 1;
            check("t4_full_count", 32'(dut.u_fifo.count_reg), 32'd8);
         end
         if (coin_in_ready && low_seen && !rise_seen) begin
            rise_seen    = 1;
            rise_pending = 1;
         end
         if (coin_in_ready) accepted++;
         @(negedge clk);
         if (rise_pending) begin
            check("t4_pop_at_rise", 32'(coin != 2'b00), 32'd1);
            rise_pending = 0;
         end
      end
      coin_in_valid = 1'b0;
      check("t4_accepted", 32'(accepted), 32'd48);
      check("t4_ready_dropped", 32'(low_seen), 32'd1);
      check("t4_ready_rose", 32'(rise_seen), 32'd1);
      repeat (100) @(negedge clk);
      n_coins = 0; n_fives = 0;
      foreach (log_q[i]) begin
         if (log_q[i] != 2'b00) n_coins++;
         if (log_q[i] == 2'b01) n_fives++;
      end
      check("t4_coins_out", 32'(n_coins), 32'd48);
      check("t4_fives_out", 32'(n_fives), 32'd48);
      check("t4_vend", 32'(vend_count), 32'd12);
      check("t4_chg", 32'(chg_count), 32'd0);
      check("t4_proto", 32'(proto_err), 32'd0);
      check("t4_drained", 32'(dut.u_fifo.count_reg), 32'd0);

      // Illegal tokens are swallowed; a stray dispense on idle flags a protocol error
      do_reset();
      push(2'b11); push(2'b00);
      repeat (10) @(negedge clk);
      check("t5_bad", 32'(bad_coin), 32'd1);
      check("t5_bufval", 32'(dut.buf_val_reg), 32'd0);
      check("t5_fifo", 32'(dut.u_fifo.count_reg), 32'd0);
      check("t5_no_burst", trace_pack(), 32'd0);
      check("t5_proto_before", 32'(proto_err), 32'd0);
      force_disp = 1'b1;
      @(negedge clk);
      force_disp = 1'b0;
      check("t5_proto_after", 32'(proto_err), 32'd1);

      // Reset mid-burst right after the first coin appears
      do_reset();
      log_en = 1'b0;
      push(2'b01); push(2'b01); push(2'b10);
      found = 0; waited = 0;
      while (!found && waited < 20) begin
         if (coin == 2'b01) found = 1;
         else begin
            @(negedge clk);
            waited++;
         end
      end
      check("t6_first_coin", 32'(found), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t6_coin", 32'(coin), 32'd0);
      check("t6_busy", 32'(busy), 32'd0);
      check("t6_fifo", 32'(dut.u_fifo.count_reg), 32'd0);
      check("t6_bufval", 32'(dut.buf_val_reg), 32'd0);
      check("t6_vend", 32'(vend_count), 32'd0);
      check("t6_proto", 32'(proto_err), 32'd0);
      repeat (10) @(negedge clk);
      check("t6_stays_idle", 32'(coin), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/coin_feeder.md
Name: coin_feeder

Overview:
- Transmit-side partner of the vending controller's coin bus.
- Buffers coin tokens pushed by a host in a small FIFO.
- Drives the 2-bit coin code toward the vending controller in back-to-back purchase bursts, because the controller drops credit on any idle cycle.
- Checks the controller's dispense/chg5 Mealy responses against a shadow credit model, and counts vends and change.

Parameters:
- DEPTH, 8: coin FIFO entries; must be ≥4, because any 4 coins total ≥20.
- CNT_W, 16: width of vend_count and chg_count, saturating.
- MIN_GAP, 1: idle (00) cycles forced on coin after each burst; must be ≥1.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- coin_in  in  2  host coin token: 01 = 5, 10 = 10
- coin_in_valid  in  1  host push request
- coin_in_ready  out  1  FIFO can accept: not full, or popping this cycle
- coin  out  2  registered coin code to the vending controller; 00 = idle
- dispense  in  1  controller dispense pulse, same cycle as the completing coin
- chg5  in  1  controller return-5 pulse
- busy  out  1  burst in progress
- vend_count  out  CNT_W  dispenses confirmed
- chg_count  out  CNT_W  chg5 pulses confirmed
- proto_err  out  1  sticky: controller response mismatched the shadow model
- bad_coin  out  1  sticky: an 00 or 11 token was pushed

Behaviour:
- Reset (rst=1 at a clk edge) produces:
  - coin=00, busy=0, vend_count=0, chg_count=0, proto_err=0, bad_coin=0.
  - FIFO empty, buf_val=0, credit=0, gap counter=0.
  - Reset mid-burst abandons the burst; buffered coins are lost. The vending controller shares rst.
- Push: a push occurs when coin_in_valid && coin_in_ready.
  - Token 01 or 10: stored, and buf_val increments by its value in 5-units.
  - Token 00 or 11: accepted but not stored; bad_coin is set.
- buf_val:
  - Tracks the sum of all FIFO entries in 5-units; width is clog2(2*DEPTH+1).
  - On a simultaneous push and pop, buf_val changes by +push value −pop value in one update.
- FSM states IDLE, SEND, GAP:
  - IDLE: coin=00. Go to SEND when buf_val ≥4 and the FIFO is non-empty.
  - SEND: busy=1. Each cycle, pop the FIFO head and drive it on coin (registered, so it appears the cycle after the pop decision). Update shadow credit: new = credit + value.
    - If new ≥4 → burst complete; credit=0; go to GAP.
    - Otherwise credit=new and stay in SEND.
    - No idle cycles inside a burst. The buf_val ≥4 start condition guarantees the FIFO cannot underrun.
  - GAP: coin=00 for MIN_GAP cycles, then IDLE. A new burst may start from IDLE on the next cycle.
- Shadow check, sampled at the clk edge ending each cycle that coin is driven:
  - Expected dispense = (credit_before + value ≥4).
  - Expected chg5 = (credit_before + value == 5), i.e. 15 + 10.
  - A dispense or chg5 mismatch sets proto_err.
  - dispense or chg5 high while coin=00 sets proto_err.
  - proto_err clears only on rst.
- Counters:
  - vend_count increments on a sampled dispense=1; chg_count increments on a sampled chg5=1.
  - Both count the controller's actual pulses, even on mismatch, and saturate at all-ones.
- Coin sequences:
  - Exact price 20: 5+5+10, 10+10, 5+5+5+5, 10+5+5.
  - Overpay: 5+5+5+10 returns 5.
  - 10+5+10: 10+5=15, then +10 = 25 → dispense + chg5.
- Full FIFO: coin_in_ready=0 unless a pop occurs the same cycle. An empty FIFO in IDLE stays IDLE indefinitely.

Decomposition:
- Shared package coin_pkg:
  - Coin code constants: COIN_IDLE=2'b00, COIN_5=2'b01, COIN_10=2'b10.
  - PRICE_U=4 (price in 5-units).
  - Function coin_val (code → 5-units).
  - FSM state typedef.
- Natural sub-module: coin_fifo.
  - Parameterised DEPTH, 2-bit data.
  - Synchronous rst, full/empty flags, simultaneous push/pop.
- coin_feeder contains the FSM, buf_val, shadow credit, checker and counters.

Test Plan:
- Push 01,01,10 with the FIFO idle → coin sequence 01,01,10 on consecutive cycles; dispense expected on the third; vend_count=1, chg_count=0, proto_err=0.
- Push 01,01,01 and wait 20 cycles → coin stays 00, busy=0, buf_val=3. Then push 10 → burst 01,01,01,10, dispense+chg5 on the last coin; vend_count=1, chg_count=1.
- Push 10,10,10,10 back-to-back → two bursts (10,10), (10,10) separated by exactly MIN_GAP idle cycles; vend_count=2.
- Fill the FIFO to DEPTH=8 with coin_in_valid held → coin_in_ready drops at 8 entries and rises in the cycle the first pop occurs; no token lost; all bursts complete.
- Push 11, then 00 → both accepted, bad_coin=1, buf_val unchanged, no burst. Force dispense=1 on an idle cycle → proto_err=1.
- Assert rst mid-burst after coin 01 → next cycle coin=00, busy=0, FIFO empty, all counters and flags 0.
